// File: rtl/clk_rst_pkg.sv
// Shared types and constants for the capture-datapath startup/reset sequencer.
package clk_rst_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StWaitLock,
        StRelease,
        StRun,
        StFault
    } state_e;

    localparam int unsigned DefNch        = 4;
    localparam int unsigned DefInitCycles = 50;
    localparam int unsigned DefLockStable = 8;
    localparam int unsigned DefStagger    = 4;
    localparam int unsigned DefHoldCycles = 16;

    // Wide enough for the largest cycle parameter, plus one bit of headroom.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync2_bit.sv
// Two-flop synchroniser for a single asynchronous level, synchronous reset to 0.
module sync2_bit (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/clk_rst_seq.sv
// Startup/reset sequencer: power-up delay, PLL-lock qualification, staggered per-channel
// reset release and lock-loss supervision with automatic re-sequencing.
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int unsigned NCH         = DefNch,
    parameter int unsigned INIT_CYCLES = DefInitCycles,
    parameter int unsigned LOCK_STABLE = DefLockStable,
    parameter int unsigned STAGGER     = DefStagger,
    parameter int unsigned HOLD_CYCLES = DefHoldCycles
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           locked,
    output logic [NCH-1:0] clk_en,
    output logic [NCH-1:0] rst_out,
    output logic           ready,
    output logic           lock_lost
);

    localparam int unsigned CW = cnt_width(INIT_CYCLES, LOCK_STABLE, STAGGER, HOLD_CYCLES);
    localparam int unsigned KW = $clog2(NCH) + 1;

    localparam logic [CW-1:0] InitLast = CW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] LockLast = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] StagLast = CW'(STAGGER - 1);
    localparam logic [CW-1:0] HoldLast = CW'(HOLD_CYCLES - 1);
    localparam logic [KW-1:0] KLast    = KW'(NCH - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [KW-1:0]  k_q, k_d;
    logic [NCH-1:0] clk_en_q, clk_en_d;
    logic [NCH-1:0] rst_out_q, rst_out_d;
    logic           ready_q, ready_d;
    logic           lock_lost_q, lock_lost_d;
    logic           locked_s;

    sync2_bit u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (locked),
        .q     (locked_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            k_q         <= '0;
            clk_en_q    <= '0;
            rst_out_q   <= '1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            clk_en_q    <= clk_en_d;
            rst_out_q   <= rst_out_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        clk_en_d    = clk_en_q;
        rst_out_d   = rst_out_q;
        ready_d     = ready_q;
        lock_lost_d = lock_lost_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
            end
            StInit: begin
                if (cnt_q == InitLast) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StWaitLock: begin
                if (!locked_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LockLast) begin
                    state_d  = StRelease;
                    clk_en_d = '1;
                    cnt_d    = '0;
                    k_d      = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StRelease: begin
                if (cnt_q == StagLast) begin
                    cnt_d = '0;
                    k_d   = k_q + KW'(1);
                    for (int unsigned i = 0; i < NCH; i++) begin
                        if (k_q == KW'(i)) rst_out_d[i] = 1'b0;
                    end
                    if (k_q == KLast) begin
                        state_d = StRun;
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StRun: begin
            end
            StFault: begin
                if (cnt_q == HoldLast) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Lock loss overrides any release scheduled on the same edge.
        if ((state_q == StRelease || state_q == StRun) && !locked_s) begin
            state_d     = StFault;
            rst_out_d   = '1;
            clk_en_d    = '0;
            ready_d     = 1'b0;
            lock_lost_d = 1'b1;
            cnt_d       = '0;
        end
    end

    assign clk_en    = clk_en_q;
    assign rst_out   = rst_out_q;
    assign ready     = ready_q;
    assign lock_lost = lock_lost_q;

endmodule

// File: doc/clk_rst_seq.md
# clk_rst_seq

Parametrised startup and reset sequencer for the capture datapath. It replaces gated-clock startup with per-channel clock enables on a single clock, and waits out a power-up delay and a PLL-lock stability window. Channel resets are then released one at a time on a fixed stagger, and a loss of lock is supervised with automatic re-sequencing. The block sits between the board clock/PLL and every downstream filter and ADC channel.

## Interface
- `NCH`, 4: number of sequenced channels (1..16)
- `INIT_CYCLES`, 50: power-up delay in cycles after `start` (≥2)
- `LOCK_STABLE`, 8: consecutive synchronised-lock cycles required (≥1)
- `STAGGER`, 4: cycles between clock-enable assertion and `rst_out[0]` release, and between successive channel releases (≥1)
- `HOLD_CYCLES`, 16: cycles spent in FAULT before re-arming (≥1)
- `clk` in 1: single system clock; all logic on its rising edge
- `reset` in 1: synchronous, active-high; overrides all other inputs
- `start` in 1: level; sampled only in IDLE
- `locked` in 1: PLL lock, asynchronous to `clk`; 2-flop synchronised internally into `locked_s`
- `clk_en` out NCH: per-channel clock enable; reset value all 0
- `rst_out` out NCH: per-channel synchronous active-high reset; reset value all 1
- `ready` out 1: all channels released; reset value 0
- `lock_lost` out 1: sticky, set on any lock loss after lock acceptance; cleared only by `reset`; reset value 0

## Operation
- States: IDLE, INIT, WAIT_LOCK, RELEASE, RUN, FAULT. The reset state is IDLE, with counter `cnt` = 0, channel index `k` = 0, and sync flops = 0.
- IDLE: if `start` = 1, go to INIT with `cnt` = 0.
- INIT: `cnt` increments each cycle. When `cnt` = INIT_CYCLES−1, go to WAIT_LOCK with `cnt` = 0. `locked` is ignored.
- WAIT_LOCK:
  - If `locked_s` = 0, `cnt` is set to 0.
  - Otherwise `cnt` increments.
  - When `locked_s` = 1 and `cnt` = LOCK_STABLE−1, go to RELEASE with `clk_en` set to all 1, `cnt` = 0, and `k` = 0.
- RELEASE: `cnt` counts 0..STAGGER−1. At `cnt` = STAGGER−1, clear `rst_out[k]`, increment `k`, and set `cnt` = 0. When releasing channel NCH−1, in the same edge go to RUN and set `ready` = 1.
- RUN: hold outputs. `start` is ignored.
- Lock supervision applies in RELEASE and RUN. If `locked_s` = 0:
  - go to FAULT;
  - `rst_out` is set to all 1, `clk_en` to all 0, `ready` to 0;
  - `lock_lost` is set to 1 and `cnt` to 0.
  - FAULT takes priority over any release scheduled in the same cycle.
- FAULT: hold for HOLD_CYCLES cycles, then go to WAIT_LOCK with `cnt` = 0. No new `start` is needed.
- Counter width is clog2 of the maximum of all cycle parameters, plus 1. `k` is clog2(NCH)+1 bits. There is no wrap-around: every compare is an equality against the parameter minus 1.
- A `reset` asserted mid-sequence returns to the reset state on the next edge, regardless of state. `lock_lost` is also cleared.

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- Number edges from E0, the edge that samples `start` = 1 in IDLE. This assumes `locked` has been high for ≥2 cycles before WAIT_LOCK.
  - `clk_en` rises after E(INIT_CYCLES+LOCK_STABLE).
  - `rst_out[j]` falls after E(INIT_CYCLES+LOCK_STABLE+(j+1)·STAGGER).
  - `ready` rises together with the fall of `rst_out[NCH−1]`.
- Lock loss: `locked` falls, then `locked_s` falls 2 edges later, then outputs respond 1 edge after that (3-edge total latency).
- After FAULT, the re-sequence from WAIT_LOCK to `ready` takes LOCK_STABLE+NCH·STAGGER edges.

## Structure
- Shared package `clk_rst_pkg`:
  - state encoding (enum of the six states);
  - default parameter constants;
  - a `clog2`-based counter width function.
- One sub-module, `sync2_bit`: a 2-flop synchroniser with synchronous reset to 0, used for `locked`.
- The FSM, counter and channel index live in `clk_rst_seq`.

## Test plan
- Reset, then `start` = 1 with `locked` = 1 throughout (defaults):
  - `clk_en` = 1111 after E58;
  - `rst_out` falls after E62, E66, E70, E74;
  - `ready` = 1 after E74;
  - `lock_lost` = 0.
- `locked` glitches low for 1 cycle at WAIT_LOCK `cnt` = 5: the counter restarts, and `clk_en` is delayed by 8 + resync cycles; no FAULT and no `lock_lost`.
- `locked` drops in RUN:
  - 3 edges later `rst_out` = 1111, `clk_en` = 0, `ready` = 0, `lock_lost` = 1;
  - with lock restored, `ready` returns 16 + 8 + 16 edges after FAULT entry.
- `locked` drops in the same cycle as the scheduled release of channel 2: `rst_out[2]` stays 1, and FAULT is entered.
- `reset` pulsed 1 cycle during RELEASE with `k` = 1: the next edge gives `rst_out` = 1111, `clk_en` = 0, `lock_lost` = 0, state IDLE; `start` held low keeps it in IDLE indefinitely.
- NCH = 1, STAGGER = 1, INIT_CYCLES = 2, LOCK_STABLE = 1: `ready` after E4, confirming the boundary parameter values.
